// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer round sequencer.
package reaction_pkg;

  localparam int CNT_W  = 13;
  localparam int LFSR_W = 16;

  localparam logic [CNT_W-1:0]  MAXCOUNT_DEF = 13'd8191;
  localparam logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DONE,
    FOUL,
    TIMEOUT
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  // Random pre-round wait: only the low counter-width bits of the LFSR are used.
  function automatic logic [CNT_W-1:0] arm_delay(input logic [LFSR_W-1:0] v,
                                                 input logic [CNT_W-1:0]  min_delay,
                                                 input logic [CNT_W-1:0]  mask);
    return min_delay + (v[CNT_W-1:0] & mask);
  endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; seeded at reset, never reseeded.
module reaction_lfsr
  import reaction_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  output logic [LFSR_W-1:0] q
);

  // Advance one step every clock in every state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q <= LFSR_SEED;
    else         q <= lfsr_next(q);
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Round sequencer for the reaction-timer game: drives the 13-bit saturating
// counter (go/en), inserts a random pre-round wait, captures the reaction count
// and flags fouls/timeouts. Optional best-score tracking: BEST_SCORE_EN.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int               TICK_DIV   = 50000,
  parameter logic [CNT_W-1:0] MIN_DELAY  = 13'd1000,
  parameter logic [CNT_W-1:0] DELAY_MASK = 13'h0FFF,
  parameter logic [CNT_W-1:0] MAXCOUNT   = MAXCOUNT_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             press,
  input  logic [CNT_W-1:0] count_in,
  output logic             cnt_go,
  output logic             cnt_en,
  output logic [CNT_W-1:0] result,
  output logic [CNT_W-1:0] best,
  output logic             led_go,
  output logic             foul,
  output logic             timeout,
  output logic             busy
`ifdef BEST_SCORE_EN
 ,output logic             new_best
`endif
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  state_t              state, state_nx;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [CNT_W-1:0]    wait_cnt;
  logic [LFSR_W-1:0]   lfsr;
  logic                arm_entry, run_entry;

  reaction_lfsr u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .q      (lfsr)
  );

  assign tick      = (presc == PRESC_LAST);
  assign arm_entry = (state_nx == ARM) && (state != ARM);
  assign run_entry = (state_nx == RUN) && (state != RUN);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state decode and counter/display outputs.
  always_comb begin
    state_nx = state;
    cnt_go   = 1'b0;
    cnt_en   = 1'b0;
    led_go   = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE, DONE, FOUL, TIMEOUT: begin
        if (start) state_nx = ARM;
      end
      ARM: begin
        busy = 1'b1;
        if (press) begin
          state_nx = FOUL;
        end else if (tick && wait_cnt == '0) begin
          state_nx = RUN;
          cnt_go   = 1'b1;
        end
      end
      RUN: begin
        busy   = 1'b1;
        led_go = 1'b1;
        cnt_en = tick;
        if (press)                      state_nx = DONE;
        else if (count_in == MAXCOUNT)  state_nx = TIMEOUT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Tick prescaler; restarting it on round entry keeps cnt_go and cnt_en apart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      presc <= '0;
    else if (arm_entry || run_entry)  presc <= '0;
    else if (tick)                    presc <= '0;
    else                              presc <= presc + 1'b1;
  end

  // Wait counter, captured result and end-of-round flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
      result   <= '0;
      foul     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (arm_entry) begin
        wait_cnt <= arm_delay(lfsr, MIN_DELAY, DELAY_MASK);
        foul     <= 1'b0;
        timeout  <= 1'b0;
      end else if (state == ARM && tick && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (state == ARM && state_nx == FOUL)    foul    <= 1'b1;
      if (state == RUN && state_nx == DONE)    result  <= count_in;
      if (state == RUN && state_nx == TIMEOUT) timeout <= 1'b1;
    end
  end

`ifdef BEST_SCORE_EN
  // Best (lowest) valid score; ties keep the earlier best.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      best     <= MAXCOUNT;
      new_best <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (state == RUN && state_nx == DONE && count_in < best) begin
        best     <= count_in;
        new_best <= 1'b1;
      end
    end
  end
`else
  assign best = '0;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a behavioural 13-bit saturating counter.
module tb_reaction_ctrl;

  localparam int          TICK_DIV   = 4;
  localparam logic [12:0] MIN_DELAY  = 13'd3;
  localparam logic [12:0] DELAY_MASK = 13'd0;
  // wait_cnt=3 decrements on ticks at cycles 3,7,11; the tick at 15 launches RUN
  localparam int          GO_K       = 15;
`ifdef BEST_SCORE_EN
  localparam logic [12:0] BEST_RST   = 13'd8191;
  localparam bit          BEST_ON    = 1'b1;
`else
  localparam logic [12:0] BEST_RST   = 13'd0;
  localparam bit          BEST_ON    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        press = 1'b0;
  logic [12:0] count = '0;
  logic        cnt_go, cnt_en, led_go, foul, timeout, busy;
  logic [12:0] result, best;
  logic        new_best;

  int checks = 0;
  int failures = 0;
  int go_cycles = 0;
  int nb_pulses = 0;
  bit overlap = 1'b0;

  reaction_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .MIN_DELAY  (MIN_DELAY),
    .DELAY_MASK (DELAY_MASK),
    .MAXCOUNT   (13'd8191)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .press    (press),
    .count_in (count),
    .cnt_go   (cnt_go),
    .cnt_en   (cnt_en),
    .result   (result),
    .best     (best),
    .led_go   (led_go),
    .foul     (foul),
    .timeout  (timeout),
    .busy     (busy)
`ifdef BEST_SCORE_EN
   ,.new_best (new_best)
`endif
  );

`ifndef BEST_SCORE_EN
  assign new_best = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural saturating counter driven by cnt_go/cnt_en.
  always @(posedge clk) begin
    if (cnt_go)                          count <= '0;
    else if (cnt_en && count != 13'h1FFF) count <= count + 13'd1;
  end

  // Event monitors, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (cnt_go) go_cycles++;
    if (cnt_go && cnt_en) overlap = 1'b1;
    if (new_best) nb_pulses++;
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_press;
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
  endtask

  task automatic wait_go(output int k);
    k = -1;
    for (int i = 0; i < 200; i++) begin
      if (cnt_go) begin k = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_count(input logic [12:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (count == v) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic play_round(input logic [12:0] v, output int k, output bit ok);
    pulse_start();
    wait_go(k);
    @(negedge clk);
    wait_count(v, ok);
    do_press();
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (cnt_go !== 1'b0)   begin failures++; $display("FAIL reset_cnt_go got=%b exp=0", cnt_go); end
    checks++; if (cnt_en !== 1'b0)   begin failures++; $display("FAIL reset_cnt_en got=%b exp=0", cnt_en); end
    checks++; if (result !== 13'd0)  begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (best !== BEST_RST) begin failures++; $display("FAIL reset_best got=%0d exp=%0d", best, BEST_RST); end
    checks++; if ({led_go, foul, timeout, busy} !== 4'b0000)
      begin failures++; $display("FAIL reset_flags got=%b exp=0000", {led_go, foul, timeout, busy}); end
    checks++; if (dut.u_lfsr.q !== 16'hACE1) begin failures++; $display("FAIL reset_lfsr got=%h exp=ace1", dut.u_lfsr.q); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (dut.u_lfsr.q !== 16'h59C3) begin failures++; $display("FAIL lfsr_step got=%h exp=59c3", dut.u_lfsr.q); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_best_tracking;
    logic [12:0] presses [3];
    logic [12:0] exp_best [3];
    int k;
    bit ok;
    presses = '{13'd40, 13'd25, 13'd30};
    exp_best = BEST_ON ? '{13'd40, 13'd25, 13'd25} : '{13'd0, 13'd0, 13'd0};
    for (int r = 0; r < 3; r++) begin
      play_round(presses[r], k, ok);
      checks++; if (k != GO_K) begin failures++; $display("FAIL best_round%0d_go_cycle got=%0d exp=%0d", r, k, GO_K); end
      checks++; if (!ok) begin failures++; $display("FAIL best_round%0d_count_reach got=0 exp=1", r); end
      checks++; if (result !== presses[r]) begin failures++; $display("FAIL best_round%0d_result got=%0d exp=%0d", r, result, presses[r]); end
      checks++; if (best !== exp_best[r]) begin failures++; $display("FAIL best_round%0d_best got=%0d exp=%0d", r, best, exp_best[r]); end
    end
    @(negedge clk);
`ifdef BEST_SCORE_EN
    checks++; if (nb_pulses != 2) begin failures++; $display("FAIL new_best_pulses got=%0d exp=2", nb_pulses); end
`endif
  endtask

  task automatic test_normal_round;
    int k, g0;
    bit ok;
    g0 = go_cycles;
    pulse_start();
    checks++; if ({busy, led_go} !== 2'b10) begin failures++; $display("FAIL arm_busy_led got=%b exp=10", {busy, led_go}); end
    wait_go(k);
    checks++; if (k != GO_K) begin failures++; $display("FAIL normal_go_cycle got=%0d exp=%0d", k, GO_K); end
    checks++; if (cnt_en !== 1'b0) begin failures++; $display("FAIL go_en_overlap got=%b exp=0", cnt_en); end
    @(negedge clk);
    checks++; if (count !== 13'd0) begin failures++; $display("FAIL run_count_clear got=%0d exp=0", count); end
    checks++; if ({busy, led_go} !== 2'b11) begin failures++; $display("FAIL run_busy_led got=%b exp=11", {busy, led_go}); end
    wait_count(13'd25, ok);
    do_press();
    checks++; if (result !== 13'd25) begin failures++; $display("FAIL normal_result got=%0d exp=25", result); end
    checks++; if ({led_go, busy, foul, timeout} !== 4'b0000)
      begin failures++; $display("FAIL done_flags got=%b exp=0000", {led_go, busy, foul, timeout}); end
    checks++; if (best !== (BEST_ON ? 13'd25 : 13'd0)) begin failures++; $display("FAIL normal_best got=%0d exp=%0d", best, BEST_ON ? 25 : 0); end
    do_press();
    repeat (2) @(negedge clk);
    checks++; if ({result, busy} !== {13'd25, 1'b0}) begin failures++; $display("FAIL done_press_ignored got=%0d/%b exp=25/0", result, busy); end
    checks++; if (go_cycles - g0 != 1) begin failures++; $display("FAIL go_pulse_width got=%0d exp=1", go_cycles - g0); end
  endtask

  task automatic test_foul;
    int g0;
    g0 = go_cycles;
    pulse_start();
    repeat (4) @(negedge clk);
    do_press();
    checks++; if (foul !== 1'b1) begin failures++; $display("FAIL foul_flag got=%b exp=1", foul); end
    checks++; if ({busy, led_go, timeout} !== 3'b000) begin failures++; $display("FAIL foul_state got=%b exp=000", {busy, led_go, timeout}); end
    checks++; if (result !== 13'd25) begin failures++; $display("FAIL foul_result got=%0d exp=25", result); end
    repeat (24) @(negedge clk);
    checks++; if (go_cycles != g0) begin failures++; $display("FAIL foul_no_go got=%0d exp=0", go_cycles - g0); end
  endtask

  task automatic test_start_ignored;
    int k, g0;
    bit ok;
    g0 = go_cycles;
    pulse_start();
    checks++; if ({foul, busy} !== 2'b01) begin failures++; $display("FAIL rearm_clear_foul got=%b exp=01", {foul, busy}); end
    repeat (5) @(negedge clk);
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arm_start_busy got=%b exp=1", busy); end
    wait_go(k);
    checks++; if (6 + k != GO_K) begin failures++; $display("FAIL arm_start_wait got=%0d exp=%0d", 6 + k, GO_K); end
    @(negedge clk);
    wait_count(13'd10, ok);
    pulse_start();
    checks++; if ({busy, led_go} !== 2'b11) begin failures++; $display("FAIL run_start_ignored got=%b exp=11", {busy, led_go}); end
    wait_count(13'd30, ok);
    do_press();
    checks++; if (result !== 13'd30) begin failures++; $display("FAIL ignored_round_result got=%0d exp=30", result); end
    checks++; if (go_cycles - g0 != 1) begin failures++; $display("FAIL ignored_round_go got=%0d exp=1", go_cycles - g0); end
  endtask

  task automatic test_timeout;
    int k;
    bit ok;
    pulse_start();
    wait_go(k);
    @(negedge clk);
    wait_count(13'd8191, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_reach got=0 exp=1"); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_timeout_busy got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", timeout); end
    checks++; if ({busy, led_go, foul} !== 3'b000) begin failures++; $display("FAIL timeout_state got=%b exp=000", {busy, led_go, foul}); end
    checks++; if (result !== 13'd30) begin failures++; $display("FAIL timeout_result got=%0d exp=30", result); end
  endtask

  task automatic test_press_at_max;
    int k;
    bit ok;
    pulse_start();
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rearm_clear_timeout got=%b exp=0", timeout); end
    wait_go(k);
    @(negedge clk);
    wait_count(13'd8191, ok);
    do_press();
    checks++; if (result !== 13'd8191) begin failures++; $display("FAIL max_press_result got=%0d exp=8191", result); end
    checks++; if ({timeout, busy} !== 2'b00) begin failures++; $display("FAIL max_press_flags got=%b exp=00", {timeout, busy}); end
    checks++; if (best !== (BEST_ON ? 13'd25 : 13'd0)) begin failures++; $display("FAIL max_press_best got=%0d exp=%0d", best, BEST_ON ? 25 : 0); end
  endtask

  task automatic test_async_reset;
    int k;
    bit ok;
    pulse_start();
    wait_go(k);
    @(negedge clk);
    wait_count(13'd10, ok);
    checks++; if (led_go !== 1'b1) begin failures++; $display("FAIL pre_reset_led got=%b exp=1", led_go); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({busy, led_go, foul, timeout, cnt_go, cnt_en} !== 6'b0)
      begin failures++; $display("FAIL async_flags got=%b exp=000000", {busy, led_go, foul, timeout, cnt_go, cnt_en}); end
    checks++; if (result !== 13'd0) begin failures++; $display("FAIL async_result got=%0d exp=0", result); end
    checks++; if (best !== BEST_RST) begin failures++; $display("FAIL async_best got=%0d exp=%0d", best, BEST_RST); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, led_go} !== 2'b00) begin failures++; $display("FAIL post_reset_idle got=%b exp=00", {busy, led_go}); end
  endtask

  initial begin
    test_reset();
    test_best_tracking();
    test_normal_round();
    test_foul();
    test_start_ignored();
    test_timeout();
    test_press_at_max();
    test_async_reset();
    checks++; if (overlap) begin failures++; $display("FAIL go_en_never_both got=1 exp=0"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
